// File: rtl/busca_instrucao_pkg.sv
// Shared constants for the instruction-fetch stage: word width, opcode field
// bounds, the bubble (NOP) word and the default halt opcode.
package busca_instrucao_pkg;

  localparam int          INSTR_W        = 32;
  localparam int          OP_MSB         = 31;
  localparam int          OP_LSB         = 26;
  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam logic [5:0]  OPCODE_HLT_DEF = 6'b111111;

  function automatic logic eh_hlt(input logic [INSTR_W-1:0] instr,
                                  input logic [5:0] opcode_hlt);
    return instr[OP_MSB:OP_LSB] == opcode_hlt;
  endfunction

endpackage

// File: rtl/busca_instrucao_memoria.sv
// Instruction memory: one synchronous read port with enable, one write port.
// A read and a write to the same word at the same edge return the old word.
module memoria_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int PROF = 256
) (
  input  logic                    clock,
  input  logic                    le,
  input  logic [$clog2(PROF)-1:0] endereco_leitura,
  output logic [INSTR_W-1:0]      dado_lido,
  input  logic                    escreve,
  input  logic [$clog2(PROF)-1:0] endereco_escrita,
  input  logic [INSTR_W-1:0]      dado_escrita
);

  logic [INSTR_W-1:0] mem_q [PROF];
  logic [INSTR_W-1:0] dado_lido_q;

  // The read samples the array before this edge's write lands.
  always_ff @(posedge clock) begin
    if (escreve) begin
      mem_q[endereco_escrita] <= dado_escrita;
    end
    if (le) begin
      dado_lido_q <= mem_q[endereco_leitura];
    end
  end

  assign dado_lido = dado_lido_q;

endmodule

// File: rtl/busca_instrucao.sv
// Fetch stage: one-cycle registered fetch with jump squash, sticky halt on the
// halt opcode, and a sticky error flag for fetches beyond the memory depth.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int          PROF       = 256,
  parameter logic [5:0]  OPCODE_HLT = OPCODE_HLT_DEF
) (
  input  logic                    clock,
  input  logic                    reseta,
  input  logic [31:0]             pc,
  input  logic                    jump,
  input  logic                    escreve,
  input  logic [$clog2(PROF)-1:0] endereco_escrita,
  input  logic [INSTR_W-1:0]      dado_escrita,
  output logic [INSTR_W-1:0]      instrucao,
  output logic [31:0]             pc_saida,
  output logic                    valida,
  output logic                    halt,
  output logic                    erro
);

  localparam int AW = $clog2(PROF);

  logic [INSTR_W-1:0] dado_lido;
  logic [31:0]        pc_saida_q;
  logic               valida_q;
  logic               halt_q;
  logic               erro_q;
  logic               congela;
  logic               fora_faixa;
  logic               le;

  assign congela    = halt_q | (valida_q & eh_hlt(dado_lido, OPCODE_HLT));
  assign fora_faixa = pc >= 32'(PROF);
  assign le         = !reseta && !congela && !jump && !fora_faixa;

  memoria_instrucao #(.PROF(PROF)) u_mem (
    .clock            (clock),
    .le               (le),
    .endereco_leitura (pc[AW-1:0]),
    .dado_lido        (dado_lido),
    .escreve          (escreve),
    .endereco_escrita (endereco_escrita),
    .dado_escrita     (dado_escrita)
  );

  always_ff @(posedge clock) begin
    if (reseta) begin
      pc_saida_q <= '0;
      valida_q   <= 1'b0;
      halt_q     <= 1'b0;
      erro_q     <= 1'b0;
    end else if (congela) begin
      halt_q <= 1'b1;
    end else if (jump) begin
      valida_q   <= 1'b0;
      pc_saida_q <= pc;
    end else if (fora_faixa) begin
      valida_q   <= 1'b0;
      erro_q     <= 1'b1;
      pc_saida_q <= pc;
    end else begin
      valida_q   <= 1'b1;
      pc_saida_q <= pc;
    end
  end

  // The read register holds during freeze, so gating it with valida is enough
  // to present NOP for bubbles without a second 32-bit register.
  assign instrucao = valida_q ? dado_lido : NOP;
  assign pc_saida  = pc_saida_q;
  assign valida    = valida_q;
  assign halt      = halt_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: directed scenarios then random traffic
// against a cycle-level behavioural model of the fetch stage.
module tb_busca_instrucao;
  import busca_instrucao_pkg::*;

  localparam int PROF = 256;

  logic        clock = 1'b0;
  logic        reseta = 1'b1;
  logic [31:0] pc = '0;
  logic        jump = 1'b0;
  logic        escreve = 1'b0;
  logic [7:0]  endereco_escrita = '0;
  logic [31:0] dado_escrita = '0;
  logic [31:0] instrucao;
  logic [31:0] pc_saida;
  logic        valida;
  logic        halt;
  logic        erro;

  always #5 clock = ~clock;

  busca_instrucao #(.PROF(PROF), .OPCODE_HLT(6'b111111)) dut (
    .clock            (clock),
    .reseta           (reseta),
    .pc               (pc),
    .jump             (jump),
    .escreve          (escreve),
    .endereco_escrita (endereco_escrita),
    .dado_escrita     (dado_escrita),
    .instrucao        (instrucao),
    .pc_saida         (pc_saida),
    .valida           (valida),
    .halt             (halt),
    .erro             (erro)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_o;
    logic        val;
    logic        hlt;
    logic        err;
    logic        chk_pc;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_mem [PROF];
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc = '0;
  logic        m_val = 1'b0;
  logic        m_halt = 1'b0;
  logic        m_erro = 1'b0;
  logic        m_pc_ok = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endfunction

  // Apply one cycle of inputs and record what the outputs must be after the edge.
  task automatic step(input logic r, input logic [31:0] p, input logic j,
                      input logic w, input int wa, input logic [31:0] wd);
    exp_t e;
    logic [5:0] op;
    @(negedge clock);
    reseta = r; pc = p; jump = j; escreve = w;
    endereco_escrita = 8'(wa); dado_escrita = wd;
    op = m_instr[31:26];
    if (r) begin
      m_instr = '0; m_pc = '0; m_val = 0; m_halt = 0; m_erro = 0; m_pc_ok = 1;
    end else if (m_halt || (m_val && op == 6'h3F)) begin
      m_halt = 1;
    end else if (j) begin
      m_instr = '0; m_val = 0; m_pc = p; m_pc_ok = 1;
    end else if (p >= PROF) begin
      m_instr = '0; m_val = 0; m_erro = 1; m_pc_ok = 0;
    end else begin
      m_instr = m_mem[p]; m_val = 1; m_pc = p; m_pc_ok = 1;
    end
    if (w) m_mem[wa] = wd;
    e.instr = m_instr; e.pc_o = m_pc; e.val = m_val;
    e.hlt = m_halt; e.err = m_erro; e.chk_pc = m_pc_ok;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] dado_normal();
    logic [31:0] d;
    d = $urandom;
    if (d[31:26] == 6'h3F) d[31] = 1'b0;
    return d;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("instrucao", instrucao, e.instr);
        check("valida", 32'(valida), 32'(e.val));
        check("halt", 32'(halt), 32'(e.hlt));
        check("erro", 32'(erro), 32'(e.err));
        if (e.chk_pc) check("pc_saida", pc_saida, e.pc_o);
      end
    end
  end

  initial begin : stim
    logic [31:0] d;
    // Program load under reset; also checks that reset outputs stay cleared.
    for (int i = 0; i < PROF; i++) begin
      case (i)
        0: d = 32'd11;
        1: d = 32'd22;
        2: d = 32'd33;
        3: d = 32'd44;
        5: d = 32'hFC00_0000;
        default: d = dado_normal();
      endcase
      step(1, 0, 0, 1, i, d);
    end
    for (int i = 0; i < 4; i++) step(0, i, 0, 0, 0, 0);
    step(0, 2, 1, 0, 0, 0);
    step(0, 3, 0, 0, 0, 0);
    step(0, 300, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 7, 0, 1, 7, 32'hAA);
    step(0, 7, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, $urandom_range(0, 20), $urandom_range(0, 1), 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      logic        r, j, w;
      logic [31:0] p;
      r = ($urandom_range(0, 63) == 0);
      j = ($urandom_range(0, 7) == 0);
      w = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0)
        p = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(256, 1000)) : ($urandom | 32'h100);
      else
        p = 32'($urandom_range(0, PROF - 1));
      d = ($urandom_range(0, 31) == 0) ? {6'h3F, 26'($urandom)} : dado_normal();
      step(r, p, j, w, $urandom_range(0, PROF - 1), d);
    end
    step(0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clock);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
